divider_log: RTL and testbench

DIVIDER_LOG -- requirements
Module: divider_log

---
 rtl/divider_log.sv | 145 ++++++++++++++
 tb/tb_divider_log.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_log.sv
// Three-stage logarithmic (Mitchell) approximate divider with a valid/ready handshake.
// Define DIVIDER_LOG_ROUND_EN to round the quotient half-up instead of truncating it.
module divider_log #(
   parameter int unsigned WIDTH_A = 16,
   parameter int unsigned WIDTH_B = 16,
   parameter bit          SIGNED  = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_A-1:0] A,
   input  logic [WIDTH_B-1:0] B,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_A-1:0] Q,
   output logic               div_zero
);

   localparam int unsigned W  = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B;
   localparam int unsigned F  = W - 1;
   localparam int unsigned KW = $clog2(W);
   localparam int unsigned LW = KW + F;
   localparam int unsigned DW = LW + 1;

   localparam logic [W:0] UMAX    = ((W+1)'(1) << WIDTH_A) - (W+1)'(1);
   localparam logic [W:0] POS_MAX = ((W+1)'(1) << (WIDTH_A - 1)) - (W+1)'(1);
   localparam logic [W:0] NEG_LIM = (W+1)'(1) << (WIDTH_A - 1);

   function automatic logic [KW-1:0] lead_one(input logic [W-1:0] v);
      lead_one = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (v[i]) lead_one = KW'(i);
      end
   endfunction

   // L = k*2^F + x, which is just the concatenation {k, x}.
   function automatic logic [LW-1:0] to_log(input logic [W-1:0] v);
      logic [KW-1:0] k;
      logic [F-1:0]  x;
      k = lead_one(v);
      x = F'(v << (F - k));
      to_log = {k, x};
   endfunction

   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // Stage 1: magnitudes and log conversion
   logic               sign_a, sign_b;
   logic [WIDTH_A-1:0] abs_a;
   logic [WIDTH_B-1:0] abs_b;
   logic [W-1:0]       mag_a, mag_b;

   always_comb begin
      sign_a = SIGNED ? A[WIDTH_A-1] : 1'b0;
      sign_b = SIGNED ? B[WIDTH_B-1] : 1'b0;
      abs_a  = sign_a ? (~A + 1'b1) : A;
      abs_b  = sign_b ? (~B + 1'b1) : B;
      mag_a  = W'(abs_a);
      mag_b  = W'(abs_b);
   end

   logic          s1_valid, s1_neg, s1_azero, s1_bzero;
   logic [LW-1:0] s1_la, s1_lb;

   // Stage 2: log-domain subtraction
   logic                 s2_valid, s2_neg, s2_azero, s2_bzero;
   logic signed [DW-1:0] s2_d;

   // Stage 3 combinational: antilog, rounding, sign and saturation
   logic signed [KW:0]   kd;
   logic [F:0]           mant;
   int                   rsh;
   logic [W:0]           mq;
   logic [WIDTH_A-1:0]   q_n;
   logic                 dz_n;
`ifdef DIVIDER_LOG_ROUND_EN
   logic [F+1:0]         ext;
`else
   logic [F:0]           ext;
`endif

   always_comb begin
      kd   = s2_d[DW-1:F];
      mant = {1'b1, s2_d[F-1:0]};
      // kd never exceeds F, so the antilog is always a right shift.
      rsh  = int'(F) - int'(kd);
`ifdef DIVIDER_LOG_ROUND_EN
      ext  = {mant, 1'b0} >> rsh;
      mq   = {1'b0, ext[F+1:1]} + (W+1)'(ext[0]);
`else
      ext  = mant >> rsh;
      mq   = {1'b0, ext};
`endif
      q_n  = '0;
      dz_n = 1'b0;
      if (s2_bzero) begin
         dz_n = 1'b1;
         q_n  = SIGNED ? POS_MAX[WIDTH_A-1:0] : UMAX[WIDTH_A-1:0];
      end else if (s2_azero) begin
         q_n = '0;
      end else if (!SIGNED) begin
         q_n = (mq > UMAX) ? UMAX[WIDTH_A-1:0] : mq[WIDTH_A-1:0];
      end else if (s2_neg) begin
         q_n = (mq > NEG_LIM) ? NEG_LIM[WIDTH_A-1:0] : (~mq[WIDTH_A-1:0] + 1'b1);
      end else begin
         q_n = (mq > POS_MAX) ? POS_MAX[WIDTH_A-1:0] : mq[WIDTH_A-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         Q         <= '0;
         div_zero  <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            Q        <= q_n;
            div_zero <= dz_n;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         s1_la    <= to_log(mag_a);
         s1_lb    <= to_log(mag_b);
         s1_neg   <= sign_a ^ sign_b;
         s1_azero <= (mag_a == '0);
         s1_bzero <= (mag_b == '0);
         s2_d     <= $signed({1'b0, s1_la}) - $signed({1'b0, s1_lb});
         s2_neg   <= s1_neg;
         s2_azero <= s1_azero;
         s2_bzero <= s1_bzero;
      end
   end

endmodule

// File: tb/tb_divider_log.sv
// Directed bench for divider_log: unsigned and signed instances, scoreboard queues,
// latency, stall/backpressure and reset-flush checks.
module tb_divider_log;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] a, b;
   logic        uin_valid, uin_ready, uout_valid, uout_ready, udz;
   logic [15:0] uq;
   logic        sin_valid, sin_ready, sout_valid, sdz;
   logic        sout_ready;
   logic [15:0] sq;

   divider_log #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(1'b0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(uin_valid), .in_ready(uin_ready), .A(a), .B(b),
      .out_valid(uout_valid), .out_ready(uout_ready), .Q(uq), .div_zero(udz)
   );

   divider_log #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(1'b1)) s_dut (
      .clk(clk), .rst(rst), .in_valid(sin_valid), .in_ready(sin_ready), .A(a), .B(b),
      .out_valid(sout_valid), .out_ready(sout_ready), .Q(sq), .div_zero(sdz)
   );

   typedef struct packed {
      logic [15:0] q;
      logic        dz;
   } exp_t;

   exp_t uexp[$];
   exp_t sexp[$];
   exp_t ue, se;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;
   int   uouts    = 0;
   int   stale    = 0;
   bit   saw_block = 1'b0;
   bit   prev_stall = 1'b0;
   logic [15:0] prev_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (uout_valid && prev_stall) check("hold_q", {16'h0, uq}, {16'h0, prev_q});
         if (uout_valid && uout_ready) begin
            uouts++;
            if (uexp.size() == 0) begin
               stale++;
               check("spurious_u", {31'h0, uout_valid}, 32'h0);
            end else begin
               ue = uexp.pop_front();
               check("u_q", {16'h0, uq}, {16'h0, ue.q});
               check("u_dz", {31'h0, udz}, {31'h0, ue.dz});
            end
         end
         if (sout_valid && sout_ready) begin
            if (sexp.size() == 0) begin
               check("spurious_s", {31'h0, sout_valid}, 32'h0);
            end else begin
               se = sexp.pop_front();
               check("s_q", {16'h0, sq}, {16'h0, se.q});
               check("s_dz", {31'h0, sdz}, {31'h0, se.dz});
            end
         end
         if (uin_valid && !uin_ready) saw_block = 1'b1;
         prev_stall = uout_valid && !uout_ready;
         prev_q     = uq;
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input bit sel, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] eq, input logic edz);
      bit done = 1'b0;
      a = av;
      b = bv;
      if (sel) sin_valid = 1'b1;
      else     uin_valid = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (sel ? sin_ready : uin_ready) begin
            if (sel) sexp.push_back('{q: eq, dz: edz});
            else     uexp.push_back('{q: eq, dz: edz});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check("send_timeout", {31'h0, done}, 32'h1);
   endtask

   task automatic idle();
      uin_valid = 1'b0;
      sin_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int t = 0; t < budget && (uexp.size() != 0 || sexp.size() != 0); t++) begin
         @(posedge clk);
         #1;
      end
      check("drain", 32'(uexp.size() + sexp.size()), 32'h0);
   endtask

   initial begin
      int lat;
      int outs0;
      rst        = 1'b1;
      a          = '0;
      b          = '0;
      uin_valid  = 1'b0;
      sin_valid  = 1'b0;
      uout_ready = 1'b1;
      sout_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'h0, uout_valid}, 32'h0);
      check("rst_q", {16'h0, uq}, 32'h0);
      check("rst_dz", {31'h0, udz}, 32'h0);
      check("rst_in_ready", {31'h0, uin_ready}, 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Latency: 100/4
      send(1'b0, 16'd100, 16'd4, 16'd25, 1'b0);
      idle();
      lat = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         lat++;
         if (uout_valid) break;
      end
      check("latency", 32'(lat), 32'd3);
      @(posedge clk);
      #1;

`ifdef DIVIDER_LOG_ROUND_EN
      send(1'b0, 16'd7, 16'd2, 16'd4, 1'b0);
`else
      send(1'b0, 16'd7, 16'd2, 16'd3, 1'b0);
`endif
      send(1'b0, 16'd3, 16'd7, 16'd0, 1'b0);
      send(1'b0, 16'd1234, 16'd0, 16'hFFFF, 1'b1);
      send(1'b0, 16'd0, 16'd9, 16'd0, 1'b0);
      send(1'b0, 16'd65535, 16'd1, 16'hFFFF, 1'b0);
      idle();
      drain(40);

      // Signed operands
      send(1'b1, 16'hFF9C, 16'd4, 16'hFFE7, 1'b0);
      send(1'b1, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b0);
      send(1'b1, 16'h8000, 16'd1, 16'h8000, 1'b0);
      send(1'b1, 16'd5, 16'd0, 16'h7FFF, 1'b1);
      send(1'b1, 16'd200, 16'hFFF8, 16'hFFE7, 1'b0);
      idle();
      drain(40);

      // Back-to-back with a 5-cycle output stall
      saw_block = 1'b0;
      outs0 = uouts;
      fork
         begin
            for (int i = 1; i <= 8; i++) send(1'b0, 16'(4 * i), 16'd4, 16'(i), 1'b0);
            idle();
         end
         begin
            for (int t = 0; t < 40; t++) begin
               @(negedge clk);
               if (uout_valid) break;
            end
            @(posedge clk);
            #1;
            uout_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            uout_ready = 1'b1;
         end
      join
      drain(60);
      check("in_ready_dropped", {31'h0, saw_block}, 32'h1);
      check("b2b_count", 32'(uouts - outs0), 32'd8);

      // Reset with three results in flight
      send(1'b0, 16'd40, 16'd4, 16'd10, 1'b0);
      send(1'b0, 16'd44, 16'd4, 16'd11, 1'b0);
      send(1'b0, 16'd48, 16'd4, 16'd12, 1'b0);
      idle();
      rst = 1'b1;
      uexp.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_flush_valid", {31'h0, uout_valid}, 32'h0);
      check("rst_flush_in_ready", {31'h0, uin_ready}, 32'h1);
      stale = 0;
      repeat (8) @(negedge clk);
      check("no_stale", 32'(stale), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
